// File: rtl/flash_pkg.sv
// Shared definitions for the boot flash loader: SPI command, ramio write
// encodings and the loader state machine states.
package flash_pkg;

   localparam logic [7:0] FlashCmdRead = 8'h03;

   localparam logic [1:0] WriteNone = 2'b00;
   localparam logic [1:0] WriteWord = 2'b11;

   typedef enum logic [2:0] {
      Idle,
      Command,
      Read,
      Write,
      WriteWait,
      Done
   } state_t;

endpackage

// File: rtl/flash_loader_if.sv
// ramio write-port bundle between the flash loader (master) and the RAM
// controller (slave).
interface flash_loader_if;

   logic        ramio_enable;
   logic [1:0]  ramio_write_type;
   logic [2:0]  ramio_read_type;
   logic [31:0] ramio_address;
   logic [31:0] ramio_data_in;
   logic        ramio_busy;

   modport master (
      output ramio_enable,
      output ramio_write_type,
      output ramio_read_type,
      output ramio_address,
      output ramio_data_in,
      input  ramio_busy
   );

   modport slave (
      input  ramio_enable,
      input  ramio_write_type,
      input  ramio_read_type,
      input  ramio_address,
      input  ramio_data_in,
      output ramio_busy
   );

endinterface

// File: rtl/flash_loader_spi_shifter.sv
// Bit-serial MSB-first SPI mode-0 shifter. Each bit is one low clk cycle
// (mosi updated) followed by one high clk cycle; miso is captured on the
// edge that ends the high phase. A new load may be issued on the finishing
// cycle so consecutive fields stream without a gap.
module spi_shifter (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [31:0] load_data,
   input  logic [4:0]  load_last,
   input  logic        miso,
   output logic        sclk,
   output logic        mosi,
   output logic        active,
   output logic        finish,
   output logic [7:0]  rx_byte
);

   logic [31:0] shift;
   logic [4:0]  count;
   logic [4:0]  last;

   assign finish  = active && sclk && (count == last);
   assign rx_byte = {shift[6:0], miso};

   // Phase generation and shifting; a load restarts with a low phase carrying the MSB.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shift  <= '0;
         count  <= '0;
         last   <= '0;
         sclk   <= 1'b0;
         mosi   <= 1'b0;
         active <= 1'b0;
      end else if (load) begin
         shift  <= load_data;
         count  <= '0;
         last   <= load_last;
         sclk   <= 1'b0;
         mosi   <= load_data[31];
         active <= 1'b1;
      end else if (active) begin
         if (!sclk) begin
            sclk <= 1'b1;
         end else begin
            sclk  <= 1'b0;
            shift <= {shift[30:0], miso};
            if (count == last) begin
               active <= 1'b0;
               mosi   <= 1'b0;
            end else begin
               count <= count + 5'd1;
               mosi  <= shift[30];
            end
         end
      end
   end

endmodule

// File: rtl/flash_loader.sv
// Boot loader: reads ByteCount bytes from SPI flash with the READ command
// and writes them as little-endian words into RAM through ramio.
module flash_loader
   import flash_pkg::*;
#(
   parameter logic [23:0] FlashStartAddress = 24'h000000,
   parameter logic [31:0] RamStartAddress   = 32'h0000_0000,
   parameter int          ByteCount         = 2048
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   start,
   output logic   done,
   output logic   flash_clk,
   input  logic   flash_miso,
   output logic   flash_mosi,
   output logic   flash_cs_n,
   flash_loader_if.master ramio
);

   localparam int WordCount  = ByteCount / 4;
   localparam int IndexWidth = $clog2(WordCount + 1);
   localparam logic [IndexWidth-1:0] LastIndex = IndexWidth'(WordCount - 1);

   if (ByteCount <= 0 || (ByteCount % 4) != 0) begin : g_bad_count
      $fatal(1, "flash_loader: ByteCount must be a nonzero multiple of 4");
   end
   if (RamStartAddress[1:0] != 2'b00) begin : g_bad_ram_address
      $fatal(1, "flash_loader: RamStartAddress must be 4-aligned");
   end

   state_t                state;
   logic [1:0]            byte_idx;
   logic [IndexWidth-1:0] word_idx;
   logic [31:0]           word;
   logic                  wait_first;
   logic                  enable_q;
   logic [1:0]            write_type_q;
   logic [31:0]           address_q;
   logic [31:0]           data_q;

   logic        sh_load;
   logic [31:0] sh_data;
   logic [4:0]  sh_last;
   logic        sh_active;
   logic        sh_finish;
   logic [7:0]  sh_rx;

   spi_shifter u_shifter (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (sh_load),
      .load_data (sh_data),
      .load_last (sh_last),
      .miso      (flash_miso),
      .sclk      (flash_clk),
      .mosi      (flash_mosi),
      .active    (sh_active),
      .finish    (sh_finish),
      .rx_byte   (sh_rx)
   );

   assign ramio.ramio_enable     = enable_q;
   assign ramio.ramio_write_type = write_type_q;
   assign ramio.ramio_read_type  = 3'b000;
   assign ramio.ramio_address    = address_q;
   assign ramio.ramio_data_in    = data_q;

   // Shifter launch: command word on entering Command, then back-to-back read bytes until a word is complete.
   always_comb begin
      sh_load = 1'b0;
      sh_data = 32'h0;
      sh_last = 5'd7;
      if (state == Command && !sh_active) begin
         sh_load = 1'b1;
         sh_data = {FlashCmdRead, FlashStartAddress};
         sh_last = 5'd31;
      end else if (state == Command && sh_finish) begin
         sh_load = 1'b1;
      end else if (state == Read && (!sh_active || (sh_finish && byte_idx != 2'd3))) begin
         sh_load = 1'b1;
      end
   end

   // Transfer sequencing, word assembly and the registered ramio/cs_n/done outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= Idle;
         done         <= 1'b0;
         flash_cs_n   <= 1'b1;
         enable_q     <= 1'b0;
         write_type_q <= WriteNone;
         address_q    <= 32'h0;
         data_q       <= 32'h0;
         word         <= 32'h0;
         byte_idx     <= 2'd0;
         word_idx     <= '0;
         wait_first   <= 1'b0;
      end else begin
         case (state)
            Idle: begin
               if (start) begin
                  flash_cs_n <= 1'b0;
                  word_idx   <= '0;
                  byte_idx   <= 2'd0;
                  state      <= Command;
               end
            end
            Command: begin
               if (sh_finish) begin
                  state <= Read;
               end
            end
            Read: begin
               if (sh_finish) begin
                  word[{byte_idx, 3'b000} +: 8] <= sh_rx;
                  byte_idx <= byte_idx + 2'd1;
                  if (byte_idx == 2'd3) begin
                     state <= Write;
                  end
               end
            end
            Write: begin
               if (!ramio.ramio_busy) begin
                  enable_q     <= 1'b1;
                  write_type_q <= WriteWord;
                  address_q    <= RamStartAddress + (32'(word_idx) << 2);
                  data_q       <= word;
                  wait_first   <= 1'b1;
                  state        <= WriteWait;
               end
            end
            WriteWait: begin
               enable_q     <= 1'b0;
               write_type_q <= WriteNone;
               if (wait_first) begin
                  wait_first <= 1'b0;
               end else if (!ramio.ramio_busy) begin
                  word_idx <= word_idx + 1'b1;
                  if (word_idx == LastIndex) begin
                     flash_cs_n <= 1'b1;
                     done       <= 1'b1;
                     state      <= Done;
                  end else begin
                     state <= Read;
                  end
               end
            end
            Done: begin
               if (start) begin
                  done       <= 1'b0;
                  flash_cs_n <= 1'b0;
                  word_idx   <= '0;
                  byte_idx   <= 2'd0;
                  state      <= Command;
               end
            end
            default: state <= Idle;
         endcase
      end
   end

endmodule

// File: tb/tb_flash_loader.sv
// Self-checking bench for flash_loader: a behavioural SPI flash, a ramio
// busy generator, and a scoreboard of expected RAM writes.
module tb_flash_loader;

   localparam logic [23:0] FlashStart = 24'h000010;
   localparam logic [31:0] RamStart   = 32'hFFFF_FFF8;
   localparam int          Bytes      = 16;
   localparam int          Words      = Bytes / 4;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] data;
   } wr_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic done;
   logic flash_clk;
   logic flash_miso = 1'b0;
   logic flash_mosi;
   logic flash_cs_n;

   flash_loader_if ramio_bus ();

   flash_loader #(
      .FlashStartAddress (FlashStart),
      .RamStartAddress   (RamStart),
      .ByteCount         (Bytes)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .done       (done),
      .flash_clk  (flash_clk),
      .flash_miso (flash_miso),
      .flash_mosi (flash_mosi),
      .flash_cs_n (flash_cs_n),
      .ramio      (ramio_bus)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passed = 0;
   wr_t exp_q[$];
   logic [7:0] flash_mem [0:255];
   int run_id = 0;

   // One comparison: counts it and reports a failure line on mismatch.
   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual === expected) passed++;
      else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
   endtask

   // Behavioural SPI flash: captures the 32-bit command on rising SCLK and
   // shifts data out MSB-first on falling SCLK from the addressed bytes.
   int cmd_bits = 0;
   int data_bits = 0;
   logic [31:0] cmd_shift = 32'h0;
   logic [7:0] cur_byte;
   logic [7:0] mem_index;
   always @(posedge flash_clk or negedge flash_clk or posedge flash_cs_n) begin
      if (flash_cs_n) begin
         cmd_bits = 0;
         data_bits = 0;
         flash_miso = 1'b0;
      end else if (flash_clk) begin
         if (cmd_bits < 32) begin
            cmd_shift = {cmd_shift[30:0], flash_mosi};
            cmd_bits++;
            if (cmd_bits == 32) checkOutput("command_word", cmd_shift, {8'h03, FlashStart});
         end
      end else if (cmd_bits == 32) begin
         mem_index = 8'(FlashStart + 24'(data_bits / 8));
         cur_byte = flash_mem[mem_index];
         flash_miso = cur_byte[7 - (data_bits % 8)];
         data_bits++;
      end
   end

   // ramio busy generator: busy after each write (20 cycles after the first
   // write of a run, short random otherwise) plus spontaneous one-cycle pulses.
   logic busy_q = 1'b0;
   logic busy_post = 1'b0;
   int remaining = 0;
   int seen_run = 0;
   initial ramio_bus.ramio_busy = 1'b0;
   always begin
      @(posedge clk);
      busy_q = ramio_bus.ramio_busy;
      #1;
      if (!rst_n) begin
         ramio_bus.ramio_busy = 1'b0;
         busy_post = 1'b0;
         remaining = 0;
      end else if (ramio_bus.ramio_enable) begin
         if (seen_run != run_id) begin
            remaining = 20;
            seen_run = run_id;
         end else begin
            remaining = $urandom_range(0, 6);
         end
         busy_post = (remaining > 0);
         ramio_bus.ramio_busy = (remaining > 0);
      end else if (remaining > 0) begin
         remaining--;
         if (remaining == 0) begin
            ramio_bus.ramio_busy = 1'b0;
            busy_post = 1'b0;
         end
      end else begin
         ramio_bus.ramio_busy = ($urandom_range(0, 3) == 0);
      end
   end

   // Monitor: SPI timing, SCLK idle while ramio is busy after a write, and
   // scoreboard comparison of every ramio strobe.
   int cycle = 0;
   int cs_fall_cycle = 0;
   int mon_rises = 0;
   int expect_rises = 64;
   logic first_rise_pending = 1'b0;
   logic prev_cs = 1'b1;
   logic prev_sclk = 1'b0;
   wr_t got;
   always @(negedge clk) begin
      cycle++;
      if (!rst_n) begin
         mon_rises = 0;
         expect_rises = 64;
         first_rise_pending = 1'b0;
         prev_cs = 1'b1;
         prev_sclk = 1'b0;
      end else begin
         if (prev_cs && !flash_cs_n) begin
            cs_fall_cycle = cycle;
            mon_rises = 0;
            expect_rises = 64;
            first_rise_pending = 1'b1;
         end
         if (!prev_sclk && flash_clk) begin
            mon_rises++;
            if (first_rise_pending) begin
               checkOutput("first_rise_delay", 32'(cycle - cs_fall_cycle), 32'd2);
               first_rise_pending = 1'b0;
            end
         end
         if (busy_post) checkOutput("sclk_idle_while_busy", {31'h0, flash_clk}, 32'h0);
         if (ramio_bus.ramio_enable) begin
            checkOutput("busy_at_strobe", {31'h0, busy_q}, 32'h0);
            checkOutput("half_periods_before_write", 32'(2 * mon_rises), 32'(2 * expect_rises));
            checkOutput("write_type", {30'h0, ramio_bus.ramio_write_type}, 32'h3);
            mon_rises = 0;
            expect_rises = 32;
            if (exp_q.size() == 0) begin
               checkOutput("unexpected_write", ramio_bus.ramio_address, 32'hDEAD_BEEF);
            end else begin
               got = exp_q.pop_front();
               checkOutput("write_address", ramio_bus.ramio_address, got.addr);
               checkOutput("write_data", ramio_bus.ramio_data_in, got.data);
            end
         end
         prev_cs = flash_cs_n;
         prev_sclk = flash_clk;
      end
   end

   // One transfer. mode 0: plain; mode 1: stray start pulses mid-transfer;
   // mode 2: reset asserted during read byte 2 of the first word.
   task automatic applyStimulus(input int mode, input bit directed);
      int t;
      int a;
      wr_t w;
      for (int i = 0; i < Bytes; i++) flash_mem[8'(FlashStart + 24'(i))] = 8'($urandom);
      if (directed) begin
         flash_mem[8'(FlashStart + 0)] = 8'h13;
         flash_mem[8'(FlashStart + 1)] = 8'h01;
         flash_mem[8'(FlashStart + 2)] = 8'h01;
         flash_mem[8'(FlashStart + 3)] = 8'h00;
         flash_mem[8'(FlashStart + 4)] = 8'hef;
         flash_mem[8'(FlashStart + 5)] = 8'h00;
         flash_mem[8'(FlashStart + 6)] = 8'h40;
         flash_mem[8'(FlashStart + 7)] = 8'h00;
      end
      if (mode != 2) begin
         for (int i = 0; i < Words; i++) begin
            a = int'(FlashStart) + 4 * i;
            w.addr = RamStart + 32'(4 * i);
            w.data = {flash_mem[8'(a + 3)], flash_mem[8'(a + 2)], flash_mem[8'(a + 1)], flash_mem[8'(a)]};
            exp_q.push_back(w);
         end
      end
      run_id++;
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      #1;
      checkOutput("done_cleared_by_start", {31'h0, done}, 32'h0);
      checkOutput("cs_low_after_start", {31'h0, flash_cs_n}, 32'h0);
      if (mode == 1) begin
         repeat (3) begin
            repeat ($urandom_range(5, 60)) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
         end
      end
      if (mode == 2) begin
         t = 0;
         while (mon_rises < 51 && t < 1000) begin
            @(negedge clk);
            #1;
            t++;
         end
         checkOutput("reach_read_byte2", 32'(mon_rises), 32'd51);
         rst_n = 1'b0;
         #1;
         checkOutput("rst_cs_n", {31'h0, flash_cs_n}, 32'h1);
         checkOutput("rst_sclk", {31'h0, flash_clk}, 32'h0);
         checkOutput("rst_mosi", {31'h0, flash_mosi}, 32'h0);
         checkOutput("rst_enable", {31'h0, ramio_bus.ramio_enable}, 32'h0);
         checkOutput("rst_done", {31'h0, done}, 32'h0);
         checkOutput("rst_address", ramio_bus.ramio_address, 32'h0);
         checkOutput("rst_data_in", ramio_bus.ramio_data_in, 32'h0);
         repeat (2) @(negedge clk);
         rst_n = 1'b1;
      end else begin
         t = 0;
         while (!done && t < 3000) begin
            @(negedge clk);
            t++;
         end
         #1;
         checkOutput("done_reached", {31'h0, done}, 32'h1);
         checkOutput("cs_high_when_done", {31'h0, flash_cs_n}, 32'h1);
         checkOutput("writes_outstanding", 32'(exp_q.size()), 32'h0);
         exp_q.delete();
         repeat (4) @(negedge clk);
      end
   endtask

   // Reset values, then a sequence of transfers covering restart from Done,
   // stray starts, mid-transfer reset and a restart from Idle.
   initial begin
      repeat (3) @(negedge clk);
      checkOutput("reset_done", {31'h0, done}, 32'h0);
      checkOutput("reset_cs_n", {31'h0, flash_cs_n}, 32'h1);
      checkOutput("reset_sclk", {31'h0, flash_clk}, 32'h0);
      checkOutput("reset_mosi", {31'h0, flash_mosi}, 32'h0);
      checkOutput("reset_enable", {31'h0, ramio_bus.ramio_enable}, 32'h0);
      checkOutput("reset_write_type", {30'h0, ramio_bus.ramio_write_type}, 32'h0);
      checkOutput("reset_read_type", {29'h0, ramio_bus.ramio_read_type}, 32'h0);
      checkOutput("reset_address", ramio_bus.ramio_address, 32'h0);
      checkOutput("reset_data_in", ramio_bus.ramio_data_in, 32'h0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      applyStimulus(0, 1'b1);
      applyStimulus(0, 1'b0);
      applyStimulus(1, 1'b0);
      applyStimulus(2, 1'b0);
      applyStimulus(0, 1'b0);
      applyStimulus(1, 1'b0);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

   // Global bound in case the DUT stalls somewhere the per-run bounds miss.
   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: simulation did not finish, %0d/%0d so far", passed, checks);
      $fatal(1, "[TB] timeout");
   end

endmodule

// File: doc/flash_loader.md
Name: flash_loader

Overview:
- SPI-mode-0 master that copies a fixed-size image from the serial boot flash into RAM through the ramio write port, then signals completion.
- It is the initiator side of the protocol implemented by the flash model: it issues READ (0x03) plus a 24-bit address and clocks data out MSB-first.
- It sits between the flash pins and ramio.
- The core holds itself idle until this block reports done, then starts fetching at address 0.

Parameters:
- FlashStartAddress, 0, 24-bit byte address sent after the 0x03 command.
- RamStartAddress, 0, byte address in ramio where word 0 is written; must be 4-aligned.
- ByteCount, 2048, bytes to copy; must be a nonzero multiple of 4 (elaboration-time $fatal otherwise).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a transfer when the block is in Idle.
- done  output  1  high from transfer completion until the next start.
- flash_clk  output  1  SPI SCLK.
- flash_miso  input  1  SPI data from flash.
- flash_mosi  output  1  SPI data to flash.
- flash_cs_n  output  1  SPI chip select, active low.
- ramio_enable  output  1  write request strobe.
- ramio_write_type  output  2  2'b11 (word) during the strobe, 2'b00 otherwise.
- ramio_read_type  output  3  constant 3'b000.
- ramio_address  output  32  byte address of the current word.
- ramio_data_in  output  32  word to write.
- ramio_busy  input  1  ramio is processing a request.

Behaviour:
- Reset values:
  - done=0, flash_clk=0, flash_mosi=0, flash_cs_n=1, ramio_enable=0, write_type=0, address=0, data_in=0.
  - State=Idle, all counters 0.
- SPI timing:
  - Each bit takes two clk cycles: a low phase (flash_clk=0, mosi updated) followed by a high phase (flash_clk=1).
  - MISO is registered on the clk edge that ends the high phase.
  - SCLK rate is therefore clk/2.
- Idle:
  - cs_n=1, sclk=0.
  - start drives cs_n=0 on the next edge and moves to Command; start is ignored in every other state.
- Command:
  - Shifts out 32 bits MSB-first: {8'h03, FlashStartAddress[23:0]}.
  - mosi carries bit 31 in the first low phase, so the first rising SCLK occurs 2 cycles after cs_n falls.
  - After the 32nd high phase, go to Read.
- Read:
  - Shifts in 8 bits MSB-first; mosi is held 0.
  - Completed byte k of a word (k = 0..3) is placed in bits [8k+7:8k] (little-endian).
  - After the 4th byte of a word, go to Write with sclk held 0 and cs_n held 0. The SPI stream pauses; the flash is edge-driven, so the pause is legal.
- Write:
  - Wait until ramio_busy=0, then assert ramio_enable for exactly one cycle with write_type=2'b11, address=RamStartAddress+4*word_index and data_in=assembled word.
  - Go to WriteWait.
- WriteWait:
  - Ignore busy for the first cycle after the strobe, then wait until busy=0.
  - Increment word_index.
  - If bytes copied == ByteCount, go to Done; otherwise return to Read.
- Done:
  - cs_n=1, sclk=0, done=1.
  - start clears done and restarts from Command with word_index reset to 0.
- Counters: bit counter 5 bits; word_index wide enough for ByteCount/4; address arithmetic is 32-bit and wraps modulo 2^32 without error.
- Reset mid-transfer deasserts cs_n immediately (asynchronously); the flash sees a new transaction on the next start.
- ramio_busy already high on entry to Write is not an error: hold until it falls, keeping enable at 0.

Decomposition:
- Shared package (flash_pkg):
  - FlashCmdRead = 8'h03.
  - ramio write_type encodings (WriteNone=2'b00, WriteWord=2'b11).
  - State enum typedef: Idle, Command, Read, Write, WriteWait, Done.
- One natural sub-module, spi_shifter: a bit-serial MSB-first shift register with sclk phase generation, used for both Command and Read.

Test Plan:
- Flash model loaded with bytes 13 01 01 00 ef 00 40 00 at address 0, ByteCount=8, start pulse:
  - mosi carries 0x03000000.
  - ramio receives writes [0]=0x00010113 and [4]=0x004000ef.
  - done=1 and cs_n=1 afterwards.
- Cycle count with ramio_busy tied 0 and ByteCount=4:
  - First SCLK rise exactly 2 cycles after cs_n falls.
  - Exactly 64+64 SCLK half-periods before the ramio_enable pulse.
- ramio_busy forced high for 20 cycles after the first write:
  - No second enable until busy falls.
  - sclk stays 0 throughout; the data sequence is unaltered.
- Full boot in the system bench (ByteCount=2048, ram.mem):
  - Core reaches the first execute with x2=0x00010000 after `lui x2,0x10`.
  - All 512 words compare equal against ram.mem.
- rst_n pulsed low in the middle of Read byte 2:
  - cs_n rises in the same cycle and all outputs return to reset values.
  - A new start produces a correct full copy.
- start pulsed during Command or Read: ignored; the transfer and the write sequence are unchanged.
